arb_muxn: RTL
=============

ARB_MUXN -- requirements
Module: arb_muxn

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels, legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 2, data bits per channel, legal range 1..64.
REQ-003 SHALL have parameter MODE, default 0; 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-004 SHALL have derived parameter SELW = max(1, ceil(log2(N))).
REQ-005 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-007 in_data  input  N*WIDTH  channel i data in bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-008 in_valid  input  N  bit i high = channel i offers a word.
REQ-009 in_ready  output  N  bit i high = channel i word accepted this cycle if valid.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_sel  output  SELW  index of the channel that supplied out_data.
REQ-012 out_valid  output  1  out_data/out_sel hold a word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.

Function
REQ-014 Transfer on any port SHALL occur only when its valid and ready are both high at a rising CLK edge.
REQ-015 The block SHALL hold one output register; load_en = !out_valid | out_ready.
REQ-016 in_ready SHALL be one-hot or zero: in_ready[i] = load_en & grant[i]; grant is combinational from in_valid and the priority pointer.
REQ-017 MODE 0: search SHALL start at index (ptr+1) mod N, wrap at N-1 -> 0, and grant the first valid channel.
REQ-018 MODE 0: ptr SHALL update to the granted index only on an input transfer; otherwise ptr holds.
REQ-019 MODE 1: grant SHALL go to the lowest-index valid channel; ptr is unused.
REQ-020 On an input transfer, out_data, out_sel, and out_valid=1 SHALL load on the same edge (latency 1 cycle, input to out_valid).
REQ-021 On an output transfer with no input transfer, out_valid SHALL clear; out_data/out_sel may retain old values.
REQ-022 Simultaneous output and input transfer SHALL replace the word with no bubble; sustained throughput 1 word/cycle with out_ready held high.
REQ-023 Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel SHALL remain stable and all in_ready SHALL be 0.
REQ-024 No in_valid high SHALL produce no grant and no change to ptr.
REQ-025 in_ready SHALL NOT depend combinationally on in_data; it SHALL depend on out_ready (pass-through permitted).
REQ-026 in_valid bits SHALL be allowed to drop without a transfer; no word is lost or duplicated because only handshaken words enter.

Reset
REQ-027 With RESET high at an edge: out_valid=0, out_data=0, out_sel=0, ptr=N-1 so channel 0 has first priority.
REQ-028 in_ready SHALL be all-zero in any cycle where RESET is high; no transfer is accepted during reset.
REQ-029 Reset asserted mid-operation SHALL discard any held output word; the next grant after release restarts from channel 0.

Verification
REQ-030 N=4, WIDTH=2, MODE 0; RESET 2 cycles; then all in_valid=1111, data ch i = i, out_ready=1 -> out_sel sequence 0,1,2,3,0,... on consecutive cycles, out_data equals out_sel, no gaps.
REQ-031 MODE 0; in_valid=0101, out_ready=1 -> grants alternate 0,2,0,2; ch1/ch3 in_ready stay 0.
REQ-032 MODE 1; in_valid=1110 -> out_sel=1 every cycle; ch2 and ch3 never granted while ch1 valid.
REQ-033 Load word (ch2, data 2'b10), then out_ready=0 for 5 cycles with in_valid=1111 -> out_data=2'b10, out_sel=2 stable, in_ready=0000 for all 5 cycles; out_ready=1 -> next word from ch3 on the following cycle.
REQ-034 Word held (out_valid=1), assert RESET 1 cycle -> out_valid=0, out_sel=0; after release with in_valid=1111 -> first grant is ch0.
REQ-035 N=16, WIDTH=64, MODE 0, random in_valid/out_ready 10k cycles -> scoreboard: every handshaken input appears exactly once at output in order; round-robin fairness: no valid channel waits more than N grants.

Source files
------------

// File: rtl/arb_muxn.sv
// N-way arbiter feeding a single registered output slot with valid/ready handshakes.
// Round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
module arb_muxn #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MODE  = 0,
  parameter int unsigned SELW  = (N < 2) ? 1 : $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SELW-1:0]  out_sel_q;
  logic             out_valid_q;

  logic             load_en;
  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  idx;
  logic [N-1:0]     grant;
  logic             in_xfer;

  // Walk the channels in priority order and take the first valid one.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= int'(N); k++) begin
      if (MODE == 0) begin
        idx = SELW'((int'(ptr_q) + k) % int'(N));
      end else begin
        idx = SELW'(k - 1);
      end
      if (!grant_any && in_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign load_en  = !out_valid_q || out_ready;
  // Reset gates the handshake so nothing is accepted while it is asserted.
  assign in_ready = (load_en && !RESET) ? grant : '0;
  assign in_xfer  = grant_any && load_en && !RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(N - 1);
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[int'(grant_idx) * int'(WIDTH) +: WIDTH];
      out_sel_q   <= grant_idx;
      ptr_q       <= grant_idx;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
